// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: access sizes, sequencer states and
// the per-size address bits that must be zero for an aligned access.
package lsu_pkg;

  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;
  localparam logic [1:0] SIZE_X = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RD   = 2'b01,
    WR   = 2'b10,
    DONE = 2'b11
  } lsu_state_t;

  localparam logic [1:0] MISALIGN_MASK_B = 2'b00;
  localparam logic [1:0] MISALIGN_MASK_H = 2'b01;
  localparam logic [1:0] MISALIGN_MASK_W = 2'b11;

  // Address bits [1:0] that must be clear for an access of this size.
  function automatic logic [1:0] misalign_mask(input logic [1:0] size);
    case (size)
      SIZE_H:  misalign_mask = MISALIGN_MASK_H;
      SIZE_W:  misalign_mask = MISALIGN_MASK_W;
      default: misalign_mask = MISALIGN_MASK_B;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: load extraction with sign/zero extension and
// sub-word store merge into the previously read memory word.
module lsu_align
  import lsu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] old_word,
  input  logic [XLEN-1:0] new_data,
  input  logic [1:0]      size,
  input  logic [1:0]      offset,
  input  logic            is_unsigned,
  output logic [XLEN-1:0] load_value,
  output logic [XLEN-1:0] merged_word
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel   = old_word[{offset, 3'b000} +: 8];
    half_sel   = offset[1] ? old_word[31:16] : old_word[15:0];
    load_value = old_word;
    case (size)
      SIZE_B:  load_value = {{(XLEN-8){byte_sel[7] & ~is_unsigned}}, byte_sel};
      SIZE_H:  load_value = {{(XLEN-16){half_sel[15] & ~is_unsigned}}, half_sel};
      default: load_value = old_word;
    endcase
  end

  // Each byte lane is either kept from the old word or replaced by the
  // matching byte of the right-aligned store data.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      logic       lane_hit;
      logic [7:0] lane_src;

      always_comb begin
        lane_hit = 1'b0;
        lane_src = new_data[8*gi +: 8];
        case (size)
          SIZE_B: begin
            lane_hit = (offset == 2'(gi));
            lane_src = new_data[7:0];
          end
          SIZE_H: begin
            lane_hit = (offset[1] == 1'(gi / 2));
            lane_src = new_data[8*(gi % 2) +: 8];
          end
          SIZE_W:  lane_hit = 1'b1;
          default: lane_hit = 1'b0;
        endcase
      end

      assign merged_word[8*gi +: 8] = lane_hit ? lane_src : old_word[8*gi +: 8];
    end

    if (XLEN > 32) begin : g_upper
      assign merged_word[XLEN-1:32] = old_word[XLEN-1:32];
    end
  endgenerate

endmodule

// File: rtl/load_store_unit.sv
// Load/store sequencer for a word-wide memory, with read-modify-write for
// sub-word stores. Define LSU_MISALIGN_FAULT_EN to fault misaligned accesses.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int ADDRESSLEN = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  reqValid,
  output logic                  reqReady,
  input  logic                  reqWrite,
  input  logic [1:0]            reqSize,
  input  logic                  reqUnsigned,
  input  logic [ADDRESSLEN-1:0] reqAddr,
  input  logic [XLEN-1:0]       reqData,
  output logic                  respValid,
  output logic [XLEN-1:0]       respData,
  output logic                  respFault,
  output logic [ADDRESSLEN-1:0] memWriteAddress,
  output logic [ADDRESSLEN-1:0] memReadAddress,
  output logic [XLEN-1:0]       memData,
  output logic                  memWriteEnabled,
  output logic                  memReadEnabled,
  input  logic [XLEN-1:0]       memOut
);

  lsu_state_t state_reg, state_next;

  logic                  write_reg;
  logic [1:0]            size_reg;
  logic                  unsigned_reg;
  logic [ADDRESSLEN-1:0] addr_reg;
  logic [XLEN-1:0]       data_reg;
  logic                  fault_reg;
  logic [XLEN-1:0]       result_reg;
  logic [XLEN-1:0]       mem_data_reg;

  logic                  accept;
  logic                  req_fault;
  logic [1:0]            req_mask;
  logic [ADDRESSLEN-1:0] req_addr_eff;
  logic [ADDRESSLEN-1:0] aligned_addr;
  logic [XLEN-1:0]       load_value;
  logic [XLEN-1:0]       merged_word;

  always_comb begin
    req_mask = misalign_mask(reqSize);
`ifdef LSU_MISALIGN_FAULT_EN
    req_fault    = (reqSize == SIZE_X) || ((reqAddr[1:0] & req_mask) != 2'b00);
    req_addr_eff = reqAddr;
`else
    // Misaligned bits are dropped so the access lands on its natural boundary.
    req_fault    = (reqSize == SIZE_X);
    req_addr_eff = {reqAddr[ADDRESSLEN-1:2], reqAddr[1:0] & ~req_mask};
`endif
  end

  assign accept       = reqValid && (state_reg == IDLE);
  assign aligned_addr = {addr_reg[ADDRESSLEN-1:2], 2'b00};
  assign memData      = mem_data_reg;

  lsu_align #(
    .XLEN(XLEN)
  ) u_align (
    .old_word    (memOut),
    .new_data    (data_reg),
    .size        (size_reg),
    .offset      (addr_reg[1:0]),
    .is_unsigned (unsigned_reg),
    .load_value  (load_value),
    .merged_word (merged_word)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next      = state_reg;
    reqReady        = 1'b0;
    respValid       = 1'b0;
    respData        = '0;
    respFault       = 1'b0;
    memReadEnabled  = 1'b0;
    memWriteEnabled = 1'b0;
    memReadAddress  = '0;
    memWriteAddress = '0;
    case (state_reg)
      IDLE: begin
        reqReady = 1'b1;
        if (reqValid) begin
          if (req_fault)              state_next = DONE;
          else if (!reqWrite)         state_next = RD;
          else if (reqSize == SIZE_W) state_next = WR;
          else                        state_next = RD;
        end
      end
      RD: begin
        memReadEnabled = 1'b1;
        memReadAddress = aligned_addr;
        state_next     = write_reg ? WR : DONE;
      end
      WR: begin
        memWriteEnabled = 1'b1;
        memWriteAddress = aligned_addr;
        state_next      = DONE;
      end
      DONE: begin
        respValid  = 1'b1;
        respData   = result_reg;
        respFault  = fault_reg;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Request capture; the read word arrives at the edge that ends RD.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      write_reg    <= 1'b0;
      size_reg     <= SIZE_B;
      unsigned_reg <= 1'b0;
      addr_reg     <= '0;
      data_reg     <= '0;
      fault_reg    <= 1'b0;
      result_reg   <= '0;
      mem_data_reg <= '0;
    end else begin
      if (accept) begin
        write_reg    <= reqWrite;
        size_reg     <= reqSize;
        unsigned_reg <= reqUnsigned;
        addr_reg     <= req_addr_eff;
        data_reg     <= reqData;
        fault_reg    <= req_fault;
        result_reg   <= '0;
        if (!req_fault && reqWrite && (reqSize == SIZE_W)) mem_data_reg <= reqData;
      end
      if (state_reg == RD) begin
        if (write_reg) mem_data_reg <= merged_word;
        else           result_reg   <= load_value;
      end
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed and random checks of load_store_unit against a byte-addressed
// reference memory; a word-wide memory model sits on the DUT's memory port.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        reqValid = 1'b0;
  logic        reqReady;
  logic        reqWrite = 1'b0;
  logic [1:0]  reqSize = 2'b00;
  logic        reqUnsigned = 1'b0;
  logic [31:0] reqAddr = '0;
  logic [31:0] reqData = '0;
  logic        respValid;
  logic [31:0] respData;
  logic        respFault;
  logic [31:0] memWriteAddress;
  logic [31:0] memReadAddress;
  logic [31:0] memData;
  logic        memWriteEnabled;
  logic        memReadEnabled;
  logic [31:0] memOut = '0;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] mem [64];
  logic [7:0]  ref_mem [256];
  int          wr_count = 0;
  int          rd_count = 0;
  logic [31:0] last_wr_addr = '0;

  load_store_unit #(
    .XLEN(32),
    .ADDRESSLEN(32)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .reqValid        (reqValid),
    .reqReady        (reqReady),
    .reqWrite        (reqWrite),
    .reqSize         (reqSize),
    .reqUnsigned     (reqUnsigned),
    .reqAddr         (reqAddr),
    .reqData         (reqData),
    .respValid       (respValid),
    .respData        (respData),
    .respFault       (respFault),
    .memWriteAddress (memWriteAddress),
    .memReadAddress  (memReadAddress),
    .memData         (memData),
    .memWriteEnabled (memWriteEnabled),
    .memReadEnabled  (memReadEnabled),
    .memOut          (memOut)
  );

  always #5 clk = ~clk;

  // Memory model: random initial contents mirrored into the reference bytes.
  initial begin
    for (int i = 0; i < 64; i++) begin
      mem[i] = $urandom;
      for (int b = 0; b < 4; b++) ref_mem[4*i+b] = mem[i][8*b +: 8];
    end
    forever begin
      @(posedge clk);
      if (memWriteEnabled) begin
        mem[memWriteAddress[7:2]] = memData;
        wr_count++;
        last_wr_addr = memWriteAddress;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (memReadEnabled) begin
        memOut = mem[memReadAddress[7:2]];
        rd_count++;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference behaviour from the access rules, on a byte-addressed memory.
  task automatic ref_access(input logic w, input logic [1:0] sz, input logic uns,
                            input logic [31:0] addr, input logic [31:0] data,
                            output logic [31:0] rd, output logic f,
                            output int lat, output int nwr, output int nrd);
    int nb;
    int a;
    longint unsigned v;
    nb = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    a = int'(addr[7:0]);
    f = (sz == 2'd3);
`ifdef LSU_MISALIGN_FAULT_EN
    if (!f && (a % nb != 0)) f = 1'b1;
`else
    if (!f) a = a - (a % nb);
`endif
    rd = '0; nwr = 0; nrd = 0; lat = 1;
    if (!f) begin
      if (w) begin
        for (int i = 0; i < nb; i++) ref_mem[a+i] = data[8*i +: 8];
        nwr = 1;
        nrd = (nb == 4) ? 0 : 1;
        lat = (nb == 4) ? 2 : 3;
      end else begin
        v = 0;
        for (int i = 0; i < nb; i++) v = v | (longint'(ref_mem[a+i]) << (8*i));
        if (!uns && nb < 4 && v[8*nb-1]) v = v | ~((64'h1 << (8*nb)) - 1);
        rd = v[31:0];
        nrd = 1;
        lat = 2;
      end
    end
  endtask

  task automatic do_op(input string name, input logic w, input logic [1:0] sz,
                       input logic uns, input logic [31:0] addr, input logic [31:0] data,
                       output logic [31:0] rdata);
    logic [31:0] exp_rd;
    logic        exp_f;
    int          exp_lat, exp_wr, exp_rd_n;
    int          wr0, rd0, k, lat;
    logic        fault;
    logic        got_valid;
    ref_access(w, sz, uns, addr, data, exp_rd, exp_f, exp_lat, exp_wr, exp_rd_n);
    wr0 = wr_count;
    rd0 = rd_count;
    @(negedge clk);
    reqValid = 1'b1; reqWrite = w; reqSize = sz; reqUnsigned = uns;
    reqAddr = addr; reqData = data;
    k = 0;
    while (!reqReady && k < 20) begin
      @(negedge clk);
      k++;
    end
    check({name, " ready"}, 32'(reqReady), 32'd1);
    @(posedge clk);
    @(negedge clk);
    reqValid = 1'b0;
    lat = 1;
    while (!respValid && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    got_valid = respValid;
    rdata = respData;
    fault = respFault;
    check({name, " valid"}, 32'(got_valid), 32'd1);
    check({name, " data"}, rdata, exp_rd);
    check({name, " fault"}, 32'(fault), 32'(exp_f));
    check({name, " latency"}, 32'(lat), 32'(exp_lat));
    @(negedge clk);
    check({name, " pulse"}, 32'(respValid), 32'd0);
    check({name, " writes"}, 32'(wr_count - wr0), 32'(exp_wr));
    check({name, " reads"}, 32'(rd_count - rd0), 32'(exp_rd_n));
    $display("txn %-10s w=%0d size=%0d uns=%0d addr=%h data=%h -> resp=%h fault=%0d lat=%0d",
             name, w, sz, uns, addr, data, rdata, fault, lat);
  endtask

  initial begin
    logic [31:0] r;
    int          wr0;
    int          viol;
    int          acc [$];
    logic [1:0]  rsz;
    logic [31:0] raddr;

    // Reset values while rst_n is held low
    #2;
    check("rst reqReady", 32'(reqReady), 32'd1);
    check("rst respValid", 32'(respValid), 32'd0);
    check("rst respData", respData, 32'd0);
    check("rst respFault", 32'(respFault), 32'd0);
    check("rst enables", {30'd0, memWriteEnabled, memReadEnabled}, 32'd0);
    check("rst wr addr", memWriteAddress, 32'd0);
    check("rst rd addr", memReadAddress, 32'd0);
    check("rst memData", memData, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    do_op("SW", 1'b1, 2'd2, 1'b0, 32'h08, 32'hDEADBEEF, r);
    check("SW wr index", last_wr_addr, 32'h08);
    do_op("LW", 1'b0, 2'd2, 1'b0, 32'h08, 32'h0, r);
    check("LW const", r, 32'hDEADBEEF);
    do_op("LB", 1'b0, 2'd0, 1'b0, 32'h0B, 32'h0, r);
    check("LB const", r, 32'hFFFFFFDE);
    do_op("LBU", 1'b0, 2'd0, 1'b1, 32'h0B, 32'h0, r);
    check("LBU const", r, 32'h000000DE);
    do_op("LH", 1'b0, 2'd1, 1'b0, 32'h08, 32'h0, r);
    check("LH const", r, 32'hFFFFBEEF);
    do_op("LHU", 1'b0, 2'd1, 1'b1, 32'h0A, 32'h0, r);
    check("LHU const", r, 32'h0000DEAD);
    do_op("SB", 1'b1, 2'd0, 1'b0, 32'h09, 32'h55, r);
    do_op("LW2", 1'b0, 2'd2, 1'b0, 32'h08, 32'h0, r);
    check("LW2 const", r, 32'hDEAD55EF);
    do_op("LW@06", 1'b0, 2'd2, 1'b0, 32'h06, 32'h0, r);
    do_op("SZ11", 1'b0, 2'd3, 1'b0, 32'h04, 32'h0, r);

    // Reset during the WR cycle of a sub-word store
    wr0 = wr_count;
    @(negedge clk);
    reqValid = 1'b1; reqWrite = 1'b1; reqSize = 2'd1; reqUnsigned = 1'b0;
    reqAddr = 32'h08; reqData = 32'h1234;
    @(posedge clk);
    @(negedge clk);
    reqValid = 1'b0;
    check("rstop RD", 32'(memReadEnabled), 32'd1);
    @(negedge clk);
    check("rstop WR", 32'(memWriteEnabled), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check("rstop we drop", 32'(memWriteEnabled), 32'd0);
    viol = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (respValid) viol++;
    end
    rst_n = 1'b1;
    @(negedge clk);
    check("rstop no resp", 32'(viol), 32'd0);
    check("rstop ready", 32'(reqReady), 32'd1);
    check("rstop no write", 32'(wr_count - wr0), 32'd0);
    $display("txn RST-SH    store aborted by reset, respValid seen %0d times", viol);
    do_op("LW3", 1'b0, 2'd2, 1'b0, 32'h08, 32'h0, r);
    check("LW3 const", r, 32'hDEAD55EF);

    // Back-to-back loads with reqValid held high
    viol = 0;
    @(negedge clk);
    reqValid = 1'b1; reqWrite = 1'b0; reqSize = 2'd2; reqAddr = 32'h10;
    for (int c = 0; c < 10; c++) begin
      if (c > 0) @(negedge clk);
      if (c == 9) reqValid = 1'b0;
      else if (reqReady) acc.push_back(c);
      if (reqReady && (memReadEnabled || respValid)) viol++;
    end
    check("b2b accepts", 32'(acc.size()), 32'd3);
    if (acc.size() == 3) begin
      check("b2b gap1", 32'(acc[1] - acc[0]), 32'd3);
      check("b2b gap2", 32'(acc[2] - acc[1]), 32'd3);
    end
    check("b2b ready low", 32'(viol), 32'd0);
    $display("txn B2B       %0d accepts, ready-busy overlaps %0d", acc.size(), viol);

    // Random traffic
    for (int n = 0; n < 40; n++) begin
      rsz = 2'($urandom_range(0, 3));
      raddr = 32'($urandom_range(0, 255));
      do_op($sformatf("R%0d", n), 1'($urandom_range(0, 1)), rsz,
            1'($urandom_range(0, 1)), raddr, $urandom, r);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
